mcdf_formatter: RTL and testbench

Output stage of the MCDF, directly downstream of the arbiter. It requests a channel ID from the arbiter, gathers one packet of 4/8/16/32 words from the selected channel into an internal FIFO, and then frames it on the formatter bus. Framing uses a req/grant handshake followed by a back-to-back burst marked with start and end flags.

---
 rtl/mcdf_pkg.sv | 27 ++
 rtl/mcdf_formatter_if.sv | 32 +++
 rtl/mcdf_fmt_fifo.sv | 59 +++++
 rtl/mcdf_formatter.sv | 135 +++++++++++++
 tb/tb_mcdf_formatter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF formatter.
//   fmt_state_e   : formatter FSM states
//   MaxPkgLen     : largest packet the formatter ever buffers (words)
//   pkglen_decode : 2-bit packet length code -> 6-bit word count
package mcdf_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StReq,
        StSend
    } fmt_state_e;

    localparam int unsigned MaxPkgLen = 32;

    function automatic logic [5:0] pkglen_decode(input logic [1:0] sel);
        logic [5:0] len;
        unique case (sel)
            2'd0:    len = 6'd4;
            2'd1:    len = 6'd8;
            2'd2:    len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcdf_formatter_if.sv
// Bundle of the arbiter-side and formatter-bus signals of the MCDF formatter.
//   master : formatter view (drives f2a_* and fmt_* except fmt_grant)
//   slave  : environment view (arbiter + downstream bus)
interface mcdf_formatter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  a2f_val;
    logic [1:0]            a2f_id;
    logic [DATA_WIDTH-1:0] a2f_data;
    logic [1:0]            a2f_pkglen_sel;
    logic                  f2a_id_req;
    logic                  f2a_ack;
    logic                  fmt_grant;
    logic                  fmt_req;
    logic [1:0]            fmt_chid;
    logic [5:0]            fmt_length;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic                  fmt_start;
    logic                  fmt_end;

    modport master (
        input  a2f_val, a2f_id, a2f_data, a2f_pkglen_sel, fmt_grant,
        output f2a_id_req, f2a_ack, fmt_req, fmt_chid, fmt_length, fmt_data, fmt_start, fmt_end
    );

    modport slave (
        output a2f_val, a2f_id, a2f_data, a2f_pkglen_sel, fmt_grant,
        input  f2a_id_req, f2a_ack, fmt_req, fmt_chid, fmt_length, fmt_data, fmt_start, fmt_end
    );

endinterface

// File: rtl/mcdf_fmt_fifo.sv
// Packet buffer for the MCDF formatter.
//   clk, rstn    : clock, asynchronous active-low clear of pointers and read data
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : read one word (ignored when empty)
//   rd_data_o    : registered read data; zero in any cycle not following a pop
//   empty_o/full_o : occupancy flags
module mcdf_fmt_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]           wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  push_en, pop_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            if (push_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
            // Read register doubles as the bus data register, so it returns to zero when idle.
            rd_data_q <= pop_en ? mem_q[rptr_q[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF output formatter: fetches a channel ID from the arbiter, buffers one packet of
// 4/8/16/32 words, then frames it on the formatter bus after a req/grant handshake.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : arbiter handshake (a2f_*, f2a_*) and formatter bus (fmt_*)
module mcdf_formatter
    import mcdf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    mcdf_formatter_if.master  bus
);

    fmt_state_e            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [1:0]            chid_q, chid_d;
    logic [5:0]            len_q, len_d;
    logic                  id_req_q, id_req_d;
    logic                  req_q, req_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;
    logic                  ack;
    logic                  fifo_push, fifo_pop;
    logic                  fifo_empty, fifo_full;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    // cnt_q counts words pushed during COLLECT and words popped during SEND.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chid_d    = chid_q;
        len_d     = len_q;
        ack       = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Only the ID/length is transferred in this cycle, never data.
                if (id_req_q && bus.a2f_val) begin
                    chid_d  = bus.a2f_id;
                    len_d   = pkglen_decode(bus.a2f_pkglen_sel);
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                ack = bus.a2f_val && (cnt_q < len_q) && !fifo_full;
                if (ack) begin
                    fifo_push = 1'b1;
                    cnt_d     = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == len_q) begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // Pop word 0 on the grant edge so it is on the bus the cycle after.
                if (bus.fmt_grant) begin
                    fifo_pop = 1'b1;
                    start_d  = 1'b1;
                    cnt_d    = 6'd1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (cnt_q < len_q) begin
                    fifo_pop = 1'b1;
                    end_d    = (cnt_q == len_q - 6'd1);
                    cnt_d    = cnt_q + 6'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        id_req_d = (state_d == StIdle);
        req_d    = (state_d == StReq);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            chid_q   <= '0;
            len_q    <= '0;
            id_req_q <= 1'b0;
            req_q    <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chid_q   <= chid_d;
            len_q    <= len_d;
            id_req_q <= id_req_d;
            req_q    <= req_d;
            start_q  <= start_d;
            end_q    <= end_d;
        end
    end

    mcdf_fmt_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (fifo_push),
        .push_data_i (bus.a2f_data),
        .pop_i       (fifo_pop),
        .rd_data_o   (fifo_rd_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // FIFO is drained by exactly len pops per packet; empty only matters after a reset mid-packet.
    logic unused_empty;
    assign unused_empty = fifo_empty;

    assign bus.f2a_id_req = id_req_q;
    assign bus.f2a_ack    = ack;
    assign bus.fmt_req    = req_q;
    assign bus.fmt_chid   = chid_q;
    assign bus.fmt_length = len_q;
    assign bus.fmt_data   = fifo_rd_data;
    assign bus.fmt_start  = start_q;
    assign bus.fmt_end    = end_q;

endmodule

// File: tb/tb_mcdf_formatter.sv
// Self-checking bench for mcdf_formatter: directed packet scenarios plus random packets,
// checked against a queue-based reference of the words the arbiter handed over.
module tb_mcdf_formatter;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mcdf_formatter_if #(.DATA_WIDTH(32)) bus ();

    mcdf_formatter #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned len_of(input logic [1:0] sel);
        return 32'd4 << sel;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_id_req"}, 64'(bus.f2a_id_req), 64'd0);
        check({tag, "_ack"},    64'(bus.f2a_ack),    64'd0);
        check({tag, "_req"},    64'(bus.fmt_req),    64'd0);
        check({tag, "_chid"},   64'(bus.fmt_chid),   64'd0);
        check({tag, "_len"},    64'(bus.fmt_length), 64'd0);
        check({tag, "_data"},   64'(bus.fmt_data),   64'd0);
        check({tag, "_start"},  64'(bus.fmt_start),  64'd0);
        check({tag, "_end"},    64'(bus.fmt_end),    64'd0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic reset_mid_packet();
        bus.a2f_val = 1'b1;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_end", 64'(bus.fmt_end), 64'd0);
            check("rst_hold_data", 64'(bus.fmt_data), 64'd0);
        end
        bus.a2f_val = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_release_id_req", 64'(bus.f2a_id_req), 64'd1);
        check("rst_release_end", 64'(bus.fmt_end), 64'd0);
    endtask

    task automatic run_packet(input logic [1:0] id, input logic [1:0] sel, input bit toggle,
                              input bit fixed_data, input int grant_delay, input bit disturb,
                              input int abort_after);
        int          exp_len;
        int          pushed;
        int          cyc;
        logic        val;
        logic [31:0] data;

        exp_len = int'(len_of(sel));
        pushed  = 0;

        cyc = 0;
        while (bus.f2a_id_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("id_req_wait", 64'(bus.f2a_id_req), 64'd1);

        bus.a2f_val        = 1'b1;
        bus.a2f_id         = id;
        bus.a2f_pkglen_sel = sel;
        bus.a2f_data       = 32'hDEAD_BEEF;
        #1;
        check("ack_in_idle", 64'(bus.f2a_ack), 64'd0);
        @(negedge clk);
        check("id_req_drop", 64'(bus.f2a_id_req), 64'd0);

        model_q.delete();
        cyc = 0;
        while (pushed < exp_len && cyc < 200) begin
            val  = toggle ? (cyc % 2 == 0) : 1'b1;
            data = fixed_data ? 32'hA0 + 32'(pushed) : $urandom;
            bus.a2f_val  = val;
            bus.a2f_data = data;
            if (disturb && pushed == exp_len / 2) begin
                bus.a2f_id         = (id == 2'd2) ? 2'd0 : id + 2'd1;
                bus.a2f_pkglen_sel = sel ^ 2'b11;
            end
            bus.fmt_grant = disturb && (cyc == 2);
            #1;
            check("ack", 64'(bus.f2a_ack), 64'(val));
            if (val) begin
                model_q.push_back(data);
                pushed++;
            end
            @(negedge clk);
            cyc++;
        end
        check("collect_count", 64'(pushed), 64'(exp_len));

        bus.fmt_grant = 1'b0;
        bus.a2f_val   = 1'b1;
        #1;
        check("ack_after_full", 64'(bus.f2a_ack), 64'd0);
        check("req_rise", 64'(bus.fmt_req), 64'd1);
        check("chid", 64'(bus.fmt_chid), 64'(id));
        check("length", 64'(bus.fmt_length), 64'(exp_len));

        for (int d = 0; d < grant_delay; d++) begin
            @(negedge clk);
            check("req_hold", 64'(bus.fmt_req), 64'd1);
            check("chid_hold", 64'(bus.fmt_chid), 64'(id));
            check("length_hold", 64'(bus.fmt_length), 64'(exp_len));
            check("data_idle", 64'(bus.fmt_data), 64'd0);
            check("ack_in_req", 64'(bus.f2a_ack), 64'd0);
        end

        bus.a2f_val   = 1'b0;
        bus.fmt_grant = 1'b1;
        @(negedge clk);
        bus.fmt_grant = 1'b0;

        for (int k = 0; k < exp_len; k++) begin
            check("send_data", 64'(bus.fmt_data), 64'(model_q[k]));
            check("send_start", 64'(bus.fmt_start), 64'(k == 0));
            check("send_end", 64'(bus.fmt_end), 64'(k == exp_len - 1));
            check("send_req_low", 64'(bus.fmt_req), 64'd0);
            if (k == abort_after) begin
                reset_mid_packet();
                return;
            end
            @(negedge clk);
        end
        check("post_id_req", 64'(bus.f2a_id_req), 64'd1);
        check("post_data", 64'(bus.fmt_data), 64'd0);
        check("post_end", 64'(bus.fmt_end), 64'd0);
    endtask

    initial begin
        rstn               = 1'b0;
        bus.a2f_val        = 1'b0;
        bus.a2f_id         = 2'd0;
        bus.a2f_data       = '0;
        bus.a2f_pkglen_sel = 2'd0;
        bus.fmt_grant      = 1'b0;

        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        rstn = 1'b1;
        #1;
        check("id_req_before_edge", 64'(bus.f2a_id_req), 64'd0);
        @(negedge clk);
        check("id_req_after_release", 64'(bus.f2a_id_req), 64'd1);

        // Length 4, channel 1, fixed data 0xA0..0xA3, valid held high.
        run_packet(2'd1, 2'd0, 1'b0, 1'b1, 0, 1'b0, -1);
        // Length 32, channel 2, valid toggling.
        run_packet(2'd2, 2'd3, 1'b1, 1'b0, 0, 1'b0, -1);
        // Length 16, channel 0: grant delayed 10 cycles, stray grant and input changes in COLLECT.
        run_packet(2'd0, 2'd2, 1'b0, 1'b0, 10, 1'b1, -1);
        // Length 8 aborted by reset after word 2, then a clean packet.
        run_packet(2'd1, 2'd1, 1'b0, 1'b0, 0, 1'b0, 2);
        run_packet(2'd2, 2'd1, 1'b1, 1'b0, 0, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_packet(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
